// File: rtl/delay_sched_pkg.sv
// Shared types and sizing helpers for the delay scheduler and its arbiter.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// One prescaled countdown timer shared round-robin among NUM_REQ one-shot delay requesters.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DELAY_W  = 16,
    parameter int PRESCALE = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         cancel,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [id_width(NUM_REQ)-1:0] active_id
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    sched_state_t       state;
    logic [DELAY_W-1:0] remaining;
    logic [PW-1:0]      presc;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic [DELAY_W-1:0] gdelay;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign gdelay    = req_delay[gidx*DELAY_W +: DELAY_W];
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        done = '0;
        if (state == DONE) done[active_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            presc     <= '0;
            active_id <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        active_id <= gidx;
                        rr_ptr    <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        remaining <= gdelay;
                        presc     <= PW'(PRESCALE - 1);
                        state     <= (gdelay == '0) ? DONE : COUNT;
                    end
                end
                COUNT: begin
                    // Cancel takes priority, even over the terminal tick.
                    if (cancel[active_id]) begin
                        state <= IDLE;
                    end else if (presc != '0) begin
                        presc <= presc - 1'b1;
                    end else begin
                        presc     <= PW'(PRESCALE - 1);
                        remaining <= remaining - 1'b1;
                        if (remaining == DELAY_W'(1)) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler with NUM_REQ=4, DELAY_W=8, PRESCALE=4.
module tb_delay_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int PS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*DW-1:0] req_delay = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] cancel = '0;
    logic [NR-1:0] done;
    logic          busy;
    logic [1:0]    active_id;

    int errors = 0;
    int checks = 0;

    delay_scheduler #(.NUM_REQ(NR), .DELAY_W(DW), .PRESCALE(PS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_delay (req_delay),
        .req_ready (req_ready),
        .cancel    (cancel),
        .done      (done),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] dly;
        logic [3:0]  grant;
        int          id;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Starts at a negedge just after the acceptance edge; counts edges until done is seen.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done == '0 && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_job(input string nm, input logic [3:0] v, input logic [31:0] d,
                           input logic [3:0] g, input int id, input int lat);
        int n;
        @(negedge clk);
        req_valid = v;
        req_delay = d;
        #1;
        chk({nm, "_grant"}, 32'(req_ready), 32'(g));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        chk({nm, "_id"}, 32'(active_id), 32'(id));
        wait_done(lat + 50, n);
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_done"}, 32'(done), 32'(g));
        @(negedge clk);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        chk({nm, "_done_off"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        logic [3:0] exp_g;

        // rr_ptr evolves across entries: 0,1,1,2,1,2,0,3 before each grant.
        tbl[0] = '{4'b0001, 32'h0000_0003, 4'b0001, 0, 12};
        tbl[1] = '{4'b0001, 32'h0000_0002, 4'b0001, 0, 8};
        tbl[2] = '{4'b1111, 32'h0101_0101, 4'b0010, 1, 4};
        tbl[3] = '{4'b0011, 32'h0000_0000, 4'b0001, 0, 0};
        tbl[4] = '{4'b1010, 32'h0200_0500, 4'b0010, 1, 20};
        tbl[5] = '{4'b1010, 32'h0200_0500, 4'b1000, 3, 8};
        tbl[6] = '{4'b0100, 32'h0001_0000, 4'b0100, 2, 4};
        tbl[7] = '{4'b0111, 32'h0000_0000, 4'b0001, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(active_id), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i].vld, tbl[i].dly,
                    tbl[i].grant, tbl[i].id, tbl[i].lat);
        end

        // Reset mid-count: outputs drop at once and the lost job never completes.
        @(negedge clk);
        req_valid = 4'b0001;
        req_delay = 32'h0000_000A;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done != '0 || busy) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        // All requesting with zero delay: grants 0,1,2,3,0 two cycles apart.
        @(negedge clk);
        req_valid = 4'b1111;
        req_delay = '0;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            chk($sformatf("b2b_grant%0d", k), 32'(req_ready), 32'(exp_g));
            @(negedge clk);
            chk($sformatf("b2b_done%0d", k), 32'(done), 32'(exp_g));
            chk($sformatf("b2b_noready%0d", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);

        // rr_ptr=1: requester 2 with D=5; non-active cancel ignored, active cancel aborts.
        req_valid = 4'b0100;
        req_delay = 32'h0005_0000;
        #1;
        chk("cancel_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        cancel = 4'b0010;
        @(posedge clk);
        #1 cancel = '0;
        @(negedge clk);
        chk("cancel_other_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        cancel = 4'b0110;
        @(posedge clk);
        #1 cancel = '0;
        @(negedge clk);
        chk("cancel_idle", 32'(busy), 32'd0);
        chk("cancel_done", 32'(done), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        chk("cancel_no_done", 32'(seen), 32'd0);

        // rr_ptr=3: longest delay on requester 3.
        run_job("maxd", 4'b1000, 32'hFF00_0000, 4'b1000, 3, 1020);

        // rr_ptr=0: cancel exactly on the terminal tick of a D=1 job.
        @(negedge clk);
        req_valid = 4'b0001;
        req_delay = 32'h0000_0001;
        #1;
        chk("term_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("term_busy", 32'(busy), 32'd1);
        cancel = 4'b0001;
        @(posedge clk);
        #1 cancel = '0;
        @(negedge clk);
        chk("term_done", 32'(done), 32'd0);
        chk("term_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        chk("term_no_done", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
